// File: rtl/gmii_arp_rx.sv
// gmii_arp_rx: GMII receive parser that qualifies frames and reports ARP requests for MY_IP.
// Define GMII_ARP_RX_FCS_CHECK_EN to gate frame acceptance on the Ethernet CRC-32.
module gmii_arp_rx #(
    parameter logic [31:0] MY_IP   = 32'h0A00_1563,
    parameter logic [47:0] MY_MAC  = 48'h0030_1BA0_A48E,
    parameter int          MAX_LEN = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    output logic        arp_valid,
    output logic [47:0] arp_sha,
    output logic [31:0] arp_spa,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt,
    output logic        busy
);
    localparam logic [10:0] MAX_IDX = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN = 11'd64;

    typedef enum logic [1:0] {IDLE, PRE, BODY, DROP} state_t;
    state_t state, state_next;

    logic [10:0] idx;
    logic        after_reset;
    logic        hit;
    logic        dst_bcast;
    logic        dst_mine;
    logic [47:0] sha_shadow;
    logic [31:0] spa_shadow;
    logic        fcs_good;

    logic        start_body;
    logic        take_byte;
    logic        count_ok;
    logic        count_err;
    logic        accept;

    logic        field_chk;
    logic [7:0]  field_exp;
    logic        dst_chk;
    logic [7:0]  dst_exp;

    assign busy = (state != IDLE);

    // Expected byte for every fixed ARP header position and for the unicast destination MAC.
    always_comb begin
        field_chk = 1'b1;
        field_exp = 8'h00;
        dst_chk   = 1'b1;
        dst_exp   = 8'h00;
        case (idx)
            11'd0:  dst_exp = MY_MAC[47:40];
            11'd1:  dst_exp = MY_MAC[39:32];
            11'd2:  dst_exp = MY_MAC[31:24];
            11'd3:  dst_exp = MY_MAC[23:16];
            11'd4:  dst_exp = MY_MAC[15:8];
            11'd5:  dst_exp = MY_MAC[7:0];
            default: dst_chk = 1'b0;
        endcase
        case (idx)
            11'd12: field_exp = 8'h08;
            11'd13: field_exp = 8'h06;
            11'd14: field_exp = 8'h00;
            11'd15: field_exp = 8'h01;
            11'd16: field_exp = 8'h08;
            11'd17: field_exp = 8'h00;
            11'd18: field_exp = 8'h06;
            11'd19: field_exp = 8'h04;
            11'd20: field_exp = 8'h00;
            11'd21: field_exp = 8'h01;
            11'd38: field_exp = MY_IP[31:24];
            11'd39: field_exp = MY_IP[23:16];
            11'd40: field_exp = MY_IP[15:8];
            11'd41: field_exp = MY_IP[7:0];
            default: field_chk = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        start_body = 1'b0;
        take_byte  = 1'b0;
        count_ok   = 1'b0;
        count_err  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // A frame already under way when reset released is skipped silently.
                if (rx_dv) begin
                    if (after_reset) begin
                        state_next = DROP;
                    end else if (rx_data == 8'h55) begin
                        state_next = PRE;
                    end else begin
                        state_next = DROP;
                        count_err  = 1'b1;
                    end
                end
            end
            PRE: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end else if (rx_data == 8'hD5) begin
                    state_next = BODY;
                    start_body = 1'b1;
                end else if (rx_data != 8'h55) begin
                    state_next = DROP;
                    count_err  = 1'b1;
                end
            end
            BODY: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    if (idx >= MIN_LEN && idx <= MAX_IDX && fcs_good) begin
                        count_ok = 1'b1;
                        accept   = hit && (dst_bcast || dst_mine);
                    end else begin
                        count_err = 1'b1;
                    end
                end else if (idx == MAX_IDX) begin
                    state_next = DROP;
                    count_err  = 1'b1;
                end else begin
                    take_byte = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            after_reset   <= 1'b1;
            idx           <= 11'd0;
            hit           <= 1'b0;
            dst_bcast     <= 1'b0;
            dst_mine      <= 1'b0;
            sha_shadow    <= 48'd0;
            spa_shadow    <= 32'd0;
            arp_valid     <= 1'b0;
            arp_sha       <= 48'd0;
            arp_spa       <= 32'd0;
            frame_ok_cnt  <= 16'd0;
            frame_err_cnt <= 16'd0;
        end else begin
            state       <= state_next;
            after_reset <= 1'b0;
            arp_valid   <= accept;
            if (start_body) begin
                idx       <= 11'd0;
                hit       <= 1'b1;
                dst_bcast <= 1'b1;
                dst_mine  <= 1'b1;
            end
            if (take_byte) begin
                idx <= idx + 11'd1;
                if (dst_chk && rx_data != 8'hFF) begin
                    dst_bcast <= 1'b0;
                end
                if (dst_chk && rx_data != dst_exp) begin
                    dst_mine <= 1'b0;
                end
                if (field_chk && rx_data != field_exp) begin
                    hit <= 1'b0;
                end
                if (idx >= 11'd22 && idx <= 11'd27) begin
                    sha_shadow <= {sha_shadow[39:0], rx_data};
                end
                if (idx >= 11'd28 && idx <= 11'd31) begin
                    spa_shadow <= {spa_shadow[23:0], rx_data};
                end
            end
            if (count_ok && frame_ok_cnt != 16'hFFFF) begin
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
            end
            if (count_err && frame_err_cnt != 16'hFFFF) begin
                frame_err_cnt <= frame_err_cnt + 16'd1;
            end
            if (accept) begin
                arp_sha <= sha_shadow;
                arp_spa <= spa_shadow;
            end
        end
    end

`ifdef GMII_ARP_RX_FCS_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Running over the FCS bytes too leaves the fixed CRC-32 residue on an intact frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc <= 32'hFFFF_FFFF;
        end else if (start_body) begin
            crc <= 32'hFFFF_FFFF;
        end else if (take_byte) begin
            crc <= crc32_byte(crc, rx_data);
        end
    end

    assign fcs_good = (crc == 32'hDEBB_20E3);
`else
    assign fcs_good = 1'b1;
`endif

endmodule

// File: tb/tb_gmii_arp_rx.sv
// tb_gmii_arp_rx: directed self-checking bench for gmii_arp_rx.
// Frames are built with a real FCS; expectations are hand-derived per scenario.
module tb_gmii_arp_rx;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic        arp_valid;
    logic [47:0] arp_sha;
    logic [31:0] arp_spa;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;
    logic        busy;

    always #5 clock = ~clock;

    gmii_arp_rx dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_dv(rx_dv),
        .rx_data(rx_data),
        .arp_valid(arp_valid),
        .arp_sha(arp_sha),
        .arp_spa(arp_spa),
        .frame_ok_cnt(frame_ok_cnt),
        .frame_err_cnt(frame_err_cnt),
        .busy(busy)
    );

    int checks = 0;
    int passed = 0;
    int pulse_count = 0;

    logic [7:0] fbuf [0:2047];
    int         flen;

    // Counts cycles with arp_valid high, so a stretched pulse shows up as an extra count.
    always @(negedge clock) begin
        if (arp_valid === 1'b1) pulse_count++;
    end

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic [7:0]  d;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            d = fbuf[8 + i];
            for (int b = 0; b < 8; b++) begin
                c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_arp(input int body_len, input logic [7:0] spa_lo, input logic [7:0] tpa_lo);
        logic [335:0] hdr;
        logic [31:0]  fcs;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h0030_1BA0_A48E, 16'h0806, 16'h0001, 16'h0800,
               8'h06, 8'h04, 16'h0001, 48'h0030_1BA0_A48E, 24'h0A0015, spa_lo,
               48'h0, 24'h0A0015, tpa_lo};
        for (int i = 0; i < 8; i++) fbuf[i] = (i == 7) ? 8'hD5 : 8'h55;
        for (int i = 0; i < body_len; i++) begin
            fbuf[8 + i] = (i < 42) ? hdr[335 - 8*i -: 8] : 8'h00;
        end
        fcs = fcs_of(body_len);
        for (int k = 0; k < 4; k++) fbuf[8 + body_len + k] = fcs[8*k +: 8];
        flen = 8 + body_len + 4;
    endtask

    task automatic send_bytes(input int from, input int upto, input int reset_at);
        for (int i = from; i < upto; i++) begin
            @(negedge clock);
            rx_dv   = 1'b1;
            rx_data = fbuf[i];
            reset_n = (i == reset_at) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic end_frame();
        @(negedge clock);
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic send_frame(input int reset_at);
        send_bytes(0, flen, reset_at);
        end_frame();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        idle(2);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (arp_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", arp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (arp_sha !== 48'd0) $display("[TB] FAIL reset_sha: got %h want 0", arp_sha); else passed++;
        checks++; if (arp_spa !== 32'd0) $display("[TB] FAIL reset_spa: got %h want 0", arp_spa); else passed++;
        checks++; if (frame_ok_cnt !== 16'd0) $display("[TB] FAIL reset_ok: got %0d want 0", frame_ok_cnt); else passed++;
        checks++; if (frame_err_cnt !== 16'd0) $display("[TB] FAIL reset_err: got %0d want 0", frame_err_cnt); else passed++;
    endtask

    task automatic test_arp_request();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(60, 8'h0A, 8'h63);
        send_frame(-1);
        @(negedge clock);
        checks++; if (arp_valid !== 1'b1) $display("[TB] FAIL req_pulse: got %b want 1", arp_valid); else passed++;
        checks++; if (arp_sha !== 48'h0030_1BA0_A48E) $display("[TB] FAIL req_sha: got %h want 00301ba0a48e", arp_sha); else passed++;
        checks++; if (arp_spa !== 32'h0A00_150A) $display("[TB] FAIL req_spa: got %h want 0a00150a", arp_spa); else passed++;
        checks++; if (frame_ok_cnt !== 16'd1) $display("[TB] FAIL req_ok: got %0d want 1", frame_ok_cnt); else passed++;
        @(negedge clock);
        checks++; if (arp_valid !== 1'b0) $display("[TB] FAIL req_pulse_end: got %b want 0", arp_valid); else passed++;
        idle(2);
        checks++; if (pulse_count - p0 !== 1) $display("[TB] FAIL req_pulses: got %0d want 1", pulse_count - p0); else passed++;
        checks++; if (frame_err_cnt !== 16'd0) $display("[TB] FAIL req_err: got %0d want 0", frame_err_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL req_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_fcs_error();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(60, 8'h0A, 8'h63);
        fbuf[flen - 1] = fbuf[flen - 1] ^ 8'h01;
        send_frame(-1);
        idle(3);
`ifdef GMII_ARP_RX_FCS_CHECK_EN
        checks++; if (pulse_count - p0 !== 0) $display("[TB] FAIL fcs_pulses: got %0d want 0", pulse_count - p0); else passed++;
        checks++; if (frame_err_cnt !== 16'd1) $display("[TB] FAIL fcs_err: got %0d want 1", frame_err_cnt); else passed++;
        checks++; if (frame_ok_cnt !== 16'd0) $display("[TB] FAIL fcs_ok: got %0d want 0", frame_ok_cnt); else passed++;
`else
        checks++; if (pulse_count - p0 !== 1) $display("[TB] FAIL fcs_pulses: got %0d want 1", pulse_count - p0); else passed++;
        checks++; if (frame_err_cnt !== 16'd0) $display("[TB] FAIL fcs_err: got %0d want 0", frame_err_cnt); else passed++;
        checks++; if (frame_ok_cnt !== 16'd1) $display("[TB] FAIL fcs_ok: got %0d want 1", frame_ok_cnt); else passed++;
`endif
    endtask

    task automatic test_wrong_tpa();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(60, 8'h0A, 8'h63);
        send_frame(-1);
        idle(2);
        build_arp(60, 8'h0C, 8'h62);
        send_frame(-1);
        idle(3);
        checks++; if (pulse_count - p0 !== 1) $display("[TB] FAIL tpa_pulses: got %0d want 1", pulse_count - p0); else passed++;
        checks++; if (frame_ok_cnt !== 16'd2) $display("[TB] FAIL tpa_ok: got %0d want 2", frame_ok_cnt); else passed++;
        checks++; if (frame_err_cnt !== 16'd0) $display("[TB] FAIL tpa_err: got %0d want 0", frame_err_cnt); else passed++;
        checks++; if (arp_spa !== 32'h0A00_150A) $display("[TB] FAIL tpa_spa_held: got %h want 0a00150a", arp_spa); else passed++;
    endtask

    task automatic test_length();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(36, 8'h0A, 8'h63);
        send_frame(-1);
        idle(3);
        checks++; if (frame_err_cnt !== 16'd1) $display("[TB] FAIL len40_err: got %0d want 1", frame_err_cnt); else passed++;
        build_arp(59, 8'h0A, 8'h63);
        send_frame(-1);
        idle(3);
        checks++; if (frame_err_cnt !== 16'd2) $display("[TB] FAIL len63_err: got %0d want 2", frame_err_cnt); else passed++;
        checks++; if (pulse_count - p0 !== 0) $display("[TB] FAIL short_pulses: got %0d want 0", pulse_count - p0); else passed++;
        build_arp(1596, 8'h0A, 8'h63);
        send_bytes(0, 8 + 1519, -1);
        @(negedge clock);
        checks++; if (frame_err_cnt !== 16'd3) $display("[TB] FAIL len1600_drop: got %0d want 3", frame_err_cnt); else passed++;
        send_bytes(8 + 1519, flen, -1);
        end_frame();
        idle(3);
        checks++; if (frame_err_cnt !== 16'd3) $display("[TB] FAIL len1600_end: got %0d want 3", frame_err_cnt); else passed++;
        checks++; if (frame_ok_cnt !== 16'd0) $display("[TB] FAIL long_ok: got %0d want 0", frame_ok_cnt); else passed++;
        build_arp(1514, 8'h0E, 8'h63);
        send_frame(-1);
        idle(3);
        checks++; if (frame_ok_cnt !== 16'd1) $display("[TB] FAIL len1518_ok: got %0d want 1", frame_ok_cnt); else passed++;
        checks++; if (pulse_count - p0 !== 1) $display("[TB] FAIL len1518_pulses: got %0d want 1", pulse_count - p0); else passed++;
        checks++; if (arp_spa !== 32'h0A00_150E) $display("[TB] FAIL len1518_spa: got %h want 0a00150e", arp_spa); else passed++;
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(60, 8'h0A, 8'h63);
        send_frame(-1);
        build_arp(60, 8'h0B, 8'h63);
        send_frame(-1);
        @(negedge clock);
        checks++; if (arp_valid !== 1'b1) $display("[TB] FAIL b2b_pulse: got %b want 1", arp_valid); else passed++;
        checks++; if (arp_spa !== 32'h0A00_150B) $display("[TB] FAIL b2b_spa: got %h want 0a00150b", arp_spa); else passed++;
        idle(2);
        checks++; if (pulse_count - p0 !== 2) $display("[TB] FAIL b2b_pulses: got %0d want 2", pulse_count - p0); else passed++;
        checks++; if (frame_ok_cnt !== 16'd2) $display("[TB] FAIL b2b_ok: got %0d want 2", frame_ok_cnt); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        do_reset();
        p0 = pulse_count;
        build_arp(60, 8'h0A, 8'h63);
        send_frame(8 + 20);
        idle(3);
        checks++; if (pulse_count - p0 !== 0) $display("[TB] FAIL midrst_pulses: got %0d want 0", pulse_count - p0); else passed++;
        checks++; if (frame_ok_cnt !== 16'd0) $display("[TB] FAIL midrst_ok: got %0d want 0", frame_ok_cnt); else passed++;
        checks++; if (frame_err_cnt !== 16'd0) $display("[TB] FAIL midrst_err: got %0d want 0", frame_err_cnt); else passed++;
        build_arp(60, 8'h0D, 8'h63);
        send_frame(-1);
        idle(3);
        checks++; if (pulse_count - p0 !== 1) $display("[TB] FAIL midrst_next_pulse: got %0d want 1", pulse_count - p0); else passed++;
        checks++; if (arp_spa !== 32'h0A00_150D) $display("[TB] FAIL midrst_next_spa: got %h want 0a00150d", arp_spa); else passed++;
        checks++; if (frame_ok_cnt !== 16'd1) $display("[TB] FAIL midrst_next_ok: got %0d want 1", frame_ok_cnt); else passed++;
    endtask

    task automatic test_preamble_errors();
        do_reset();
        fbuf[0] = 8'h12; fbuf[1] = 8'h55; fbuf[2] = 8'hD5; flen = 3;
        send_frame(-1);
        idle(2);
        checks++; if (frame_err_cnt !== 16'd1) $display("[TB] FAIL pre_bad_first: got %0d want 1", frame_err_cnt); else passed++;
        fbuf[0] = 8'h55; fbuf[1] = 8'h55; fbuf[2] = 8'h33; flen = 3;
        send_frame(-1);
        idle(2);
        checks++; if (frame_err_cnt !== 16'd2) $display("[TB] FAIL pre_bad_mid: got %0d want 2", frame_err_cnt); else passed++;
        fbuf[0] = 8'h55; fbuf[1] = 8'h55; flen = 2;
        send_frame(-1);
        idle(2);
        checks++; if (frame_err_cnt !== 16'd2) $display("[TB] FAIL pre_abort: got %0d want 2", frame_err_cnt); else passed++;
        fbuf[0] = 8'hD5; flen = 1;
        send_frame(-1);
        idle(2);
        checks++; if (frame_err_cnt !== 16'd3) $display("[TB] FAIL pre_sfd_only: got %0d want 3", frame_err_cnt); else passed++;
        checks++; if (frame_ok_cnt !== 16'd0) $display("[TB] FAIL pre_ok: got %0d want 0", frame_ok_cnt); else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        $display("[TB] starting gmii_arp_rx bench");
        test_reset();
        test_arp_request();
        test_fcs_error();
        test_wrong_tpa();
        test_length();
        test_back_to_back();
        test_reset_mid_frame();
        test_preamble_errors();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
